// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants.
//   XLEN           - default architectural register width
//   REG_ADDR_W     - default register address width
//   NUM_RD_DEFAULT - default number of register-file read ports
//   DEPTH          - register count implied by REG_ADDR_W
package cpu_pkg;
  localparam int XLEN           = 64;
  localparam int REG_ADDR_W     = 5;
  localparam int NUM_RD_DEFAULT = 2;
  localparam int DEPTH          = 1 << REG_ADDR_W;
endpackage

// File: rtl/register_file_mp_if.sv
// Bus between decode/writeback (master) and the register file (slave).
//   E                 - block enable; low freezes all state and outputs
//   rd_addr           - packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data           - packed registered read data, port k at [k*DATA_W +: DATA_W]
//   rd_pend           - registered pending flag per read port
//   wr_en/addr/data   - writeback strobe, register and value
//   rsv_en/addr       - decode reserves a destination register
//   any_pend          - registered OR of all pending bits
interface register_file_mp_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NUM_RD = NUM_RD_DEFAULT
) ();
  logic                     E;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pend;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     any_pend;

  modport master (
    output E, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_pend, any_pend
  );

  modport slave (
    input  E, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_pend, any_pend
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending bits for the hazard unit.
//   clk, rst          - clock, synchronous active-high reset
//   en                - enable; low holds pending bits and outputs
//   wr_en, wr_addr    - writeback clears the pending bit of its register
//   rsv_en, rsv_addr  - reservation sets the pending bit of its register
//   rd_addr           - packed read addresses (one per port)
//   rd_pend           - registered post-edge pending bit per read port
//   any_pend          - registered OR of all post-edge pending bits
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_RD   = NUM_RD_DEFAULT,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_pend,
  output logic                     any_pend
);
  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_nxt;
  logic [NUM_RD-1:0]   rd_pend_nxt;
  logic                wr_ok;
  logic                rsv_ok;

  assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // Reserve is applied after the clear so a same-edge write+reserve
  // leaves the register pending for the new producer.
  always_comb begin
    pend_nxt = pend_q;
    if (wr_ok)  pend_nxt[wr_addr]  = 1'b0;
    if (rsv_ok) pend_nxt[rsv_addr] = 1'b1;
  end

  // Lookups use the post-edge bits so same-edge write/reserve are visible.
  always_comb begin
    rd_pend_nxt = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (!((ZERO_REG != 0) && (rd_addr[k*ADDR_W +: ADDR_W] == '0)))
        rd_pend_nxt[k] = pend_nxt[rd_addr[k*ADDR_W +: ADDR_W]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      rd_pend  <= '0;
      any_pend <= 1'b0;
    end else if (en) begin
      pend_q   <= pend_nxt;
      rd_pend  <= rd_pend_nxt;
      any_pend <= |pend_nxt;
    end
  end
endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with write-first bypass, optional hardwired
// zero register and a per-register pending scoreboard.
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset; clears registers, pending bits and outputs
//   bus  - slave side of register_file_mp_if (read, writeback, reserve, status)
module register_file_mp
  import cpu_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_RD   = NUM_RD_DEFAULT,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  register_file_mp_if.slave  bus
);
  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0]        regs [NUM_REGS];
  logic [DATA_W-1:0]        rd_nxt [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_data_p1;
  logic [NUM_RD-1:0]        rd_pend_p1;
  logic                     any_pend_p1;
  logic                     wr_ok;

  assign wr_ok = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (bus.E && wr_ok) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read muxes: zero register first, then write-first bypass, then array.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_nxt[k] = ((ZERO_REG != 0) && (addr == '0)) ? '0 :
                       (bus.wr_en && (bus.wr_addr == addr)) ? bus.wr_data :
                       regs[addr];
  end

  // Stage p1: registered read data
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_p1 <= '0;
    end else if (bus.E) begin
      for (int k = 0; k < NUM_RD; k++) rd_data_p1[k*DATA_W +: DATA_W] <= rd_nxt[k];
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.E),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .rd_addr  (bus.rd_addr),
    .rd_pend  (rd_pend_p1),
    .any_pend (any_pend_p1)
  );

  assign bus.rd_data  = rd_data_p1;
  assign bus.rd_pend  = rd_pend_p1;
  assign bus.any_pend = any_pend_p1;
endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-read-port register file for the pipelined CPU datapath. It generalises the fixed 64-bit, 2-read-port register file in four ways:
- configurable width, depth and read-port count;
- optional hardwired zero register;
- write-first bypass;
- a per-register pending (scoreboard) bit, so the hazard unit can tell which operands still await an in-flight producer.

It sits between decode (read/reserve) and writeback (write).

## Interface
Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 always reads 0 and is never pending

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- E  in  1  block enable; when low all state and outputs hold
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data; port k at [k*DATA_W +: DATA_W]
- rd_pend  out  NUM_RD  registered pending flag per read port
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback register
- wr_data  in  DATA_W  writeback value
- rsv_en  in  1  decode reserves a destination (marks it pending)
- rsv_addr  in  ADDR_W  register being reserved
- any_pend  out  1  registered OR of all pending bits (drain/flush indicator)

## Operation
- Reset (rst=1 at an edge, E ignored):
  - all DEPTH registers cleared to 0 in that one cycle;
  - all pending bits cleared;
  - rd_data, rd_pend and any_pend forced to 0.
  - rst has priority over every other input.
- Write: on an edge with E=1 and wr_en=1, reg[wr_addr] <= wr_data and pend[wr_addr] <= 0.
  - Ignored when ZERO_REG=1 and wr_addr=0.
- Reserve: on an edge with E=1 and rsv_en=1, pend[rsv_addr] <= 1.
  - Ignored when ZERO_REG=1 and rsv_addr=0.
- Write and reserve to the same address on the same edge: data is written, and the pending bit ends at 1 (the new producer wins).
- Read, per port k, on an edge with E=1:
  - rd_data[k] <= 0 if ZERO_REG and the address is 0;
  - else wr_data if wr_en and wr_addr equals the read address (write-first bypass);
  - else reg[address].
- Pending read, per port k: rd_pend[k] <= the post-edge value of pend for that address.
  - Consequently a same-edge write to the address clears the flag, and a same-edge reserve sets it.
- Ports are independent; several ports may read the same address.
- E=0: no write, no reserve, rd_data, rd_pend and any_pend hold their previous values.
- any_pend <= the OR of the post-edge pending bits.

## Timing
- Read latency: 1 cycle. The address presented before edge N appears on rd_data/rd_pend after edge N.
- A write at edge N is visible to a read sampled at the same edge N via the bypass. There is no read-after-write bubble.
- Reserve at edge N: rd_pend is 1 for reads of that address sampled at edge N and later, until the edge that writes it.
- Reset takes effect at the first edge with rst=1; outputs are 0 from that edge onward.
- A reserve or write coinciding with reset is discarded.
- All outputs come from flops; there are no combinational input-to-output paths.

## Structure
- Shared package cpu_pkg holds:
  - default constants XLEN=64 and REG_ADDR_W=5;
  - NUM_RD_DEFAULT=2;
  - the localparam DEPTH = 1 << REG_ADDR_W.
- Sub-module reg_scoreboard: DEPTH pending bits with the set/clear priority rules, zero-register masking, read lookup and the any_pend reduction. It is instantiated once.
- The data array, bypass muxes and read flops stay in the top module, using a generate loop over NUM_RD.

## Test plan
- Reset: preload reg 7 = 0xDEAD and reserve 7, then pulse rst for one cycle, then read 7. Required: rd_data=0, rd_pend=0, any_pend=0.
- Write-first bypass: wr_en with wr_addr=3 and wr_data=0x1234, while port 0 and port 1 both read 3 at the same edge. Required: both show 0x1234 one cycle later.
- Zero register (ZERO_REG=1): write 0xFFFF to reg 0 and reserve reg 0, then read 0. Required: rd_data=0, rd_pend=0, any_pend=0.
- Scoreboard lifecycle:
  - reserve 5 at edge 1, then read 5 at edge 2 → rd_pend=1, any_pend=1;
  - write 5 = 0xAA at edge 3 with a concurrent read of 5 → rd_data=0xAA, rd_pend=0.
  - Then simultaneously write and reserve 9 → pend[9] reads 1.
- Enable stall: with E=0, change rd_addr and assert wr_en for reg 2 = 0x55. Required: outputs hold, and after E returns high reg 2 still has its old value.
- Parameter sweep: re-run the bypass and scoreboard cases with DATA_W=32, ADDR_W=4, NUM_RD=3 and ZERO_REG=0. Required: register 0 is writable and can be reserved.
